// File: rtl/risc_core_mc_if.sv
// Instruction/result bundle between an instruction source and risc_core_mc.
interface risc_core_mc_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              result_valid;
  logic [DATA_W-1:0] result;
  logic [3:0]        result_rd;
  logic              illegal;
  logic              busy;

  // An instruction transfers on a rising edge with instr_valid && instr_ready; the source holds
  // instr stable until then. result_valid is a one-cycle strobe with no back-pressure.
  modport master (
    output instr_valid, instr,
    input  instr_ready, result_valid, result, result_rd, illegal, busy
  );
  modport slave (
    input  instr_valid, instr,
    output instr_ready, result_valid, result, result_rd, illegal, busy
  );
endinterface

// File: rtl/risc_core_mc.sv
// Multi-cycle 16-bit-instruction RISC core: IDLE -> EXEC -> (MUL) -> WB.
// Define RISC_MUL_EN to build the iterative shift-add multiplier for opcode 8.
module risc_core_mc #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  risc_core_mc_if.slave        bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam int         SH_W  = $clog2(DATA_W);
  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_instr;
  logic [DATA_W-1:0] r_regs [16];
  logic [DATA_W-1:0] r_result;

  logic [3:0]        w_op;
  logic [3:0]        w_rs1;
  logic [3:0]        w_rs2;
  logic [3:0]        w_rd;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  logic              w_illegal;
  logic              w_is_mul;
  logic              w_wr_en;

  assign w_op  = r_instr[15:12];
  assign w_rs1 = r_instr[11:8];
  assign w_rs2 = r_instr[7:4];
  assign w_rd  = r_instr[3:0];

  // r0 and addresses beyond the configured register count read as zero.
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (w_rs1 != 4'd0 && {1'b0, w_rs1} < NREGS) w_a = r_regs[w_rs1];
    if (w_rs2 != 4'd0 && {1'b0, w_rs2} < NREGS) w_b = r_regs[w_rs2];
  end

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (w_op)
      4'h0: w_alu = w_a + w_b;
      4'h1: w_alu = w_a - w_b;
      4'h2: w_alu = w_a & w_b;
      4'h3: w_alu = w_a | w_b;
      4'h4: w_alu = w_a ^ w_b;
      4'h5: w_alu = w_a << w_b[SH_W-1:0];
      4'h6: w_alu = w_a >> w_b[SH_W-1:0];
      4'h7: w_alu = ($signed(w_a) < $signed(w_b)) ? DATA_W'(1) : '0;
      4'h8: begin
`ifndef RISC_MUL_EN
        w_illegal = 1'b1;
`endif
      end
      4'h9: w_alu = DATA_W'(r_instr[11:4]);
      4'hF: w_alu = '0;
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef RISC_MUL_EN
  assign w_is_mul = (w_op == 4'h8);
`else
  assign w_is_mul = 1'b0;
`endif

  assign w_wr_en = !w_illegal && (w_op != 4'hF) && (w_rd != 4'd0) && ({1'b0, w_rd} < NREGS);

`ifdef RISC_MUL_EN
  localparam int               CNT_W    = (SH_W < 1) ? 1 : SH_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // One multiplier bit per cycle; after DATA_W steps r_acc holds the low product bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (r_state == S_EXEC) begin
      r_cnt    <= '0;
      r_mcand  <= w_a;
      r_mplier <= w_b;
      r_acc    <= '0;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + 1'b1;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.instr_valid) w_next = S_EXEC;
      S_EXEC: w_next = w_is_mul ? S_MUL : S_WB;
`ifdef RISC_MUL_EN
      S_MUL:  if (r_cnt == CNT_LAST) w_next = S_WB;
`endif
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr  <= '0;
      r_result <= '0;
    end else begin
      if (r_state == S_IDLE && bus.instr_valid) r_instr <= bus.instr;
      if (r_state == S_EXEC) r_result <= w_alu;
`ifdef RISC_MUL_EN
      if (r_state == S_MUL && r_cnt == CNT_LAST) r_result <= w_acc_next;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (r_state == S_WB && w_wr_en) begin
      r_regs[w_rd] <= r_result;
    end
  end

  always_comb begin
    bus.instr_ready  = (r_state == S_IDLE);
    bus.busy         = (r_state != S_IDLE);
    bus.result_valid = (r_state == S_WB);
    bus.result       = '0;
    bus.result_rd    = '0;
    bus.illegal      = 1'b0;
    if (r_state == S_WB) begin
      bus.result    = r_result;
      bus.result_rd = w_rd;
      bus.illegal   = w_illegal;
    end
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_risc_core_mc.sv
// Randomized bench for risc_core_mc against an arithmetic reference model and expected queue.
module tb_risc_core_mc;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int W        = DATA_W + 5;
`ifdef RISC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        dbg_state;
  int                n_total = 0;
  int                n_bad   = 0;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] m_regs [16];

  risc_core_mc_if #(.DATA_W(DATA_W)) bus ();

  risc_core_mc #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] rs1,
                                     input logic [3:0] rs2, input logic [3:0] rd);
    return {op, rs1, rs2, rd};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h9, imm, rd};
  endfunction

  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] a);
    return (a == 4'd0) ? '0 : m_regs[a];
  endfunction

  // Reference: plain 64-bit arithmetic truncated to DATA_W, then architectural register update.
  function automatic void model(input logic [15:0] ins, output logic [DATA_W-1:0] res,
                                output logic ill);
    longint unsigned a, b, mask;
    int              sh;
    logic [3:0]      op;
    op   = ins[15:12];
    a    = 64'(rd_reg(ins[11:8]));
    b    = 64'(rd_reg(ins[7:4]));
    mask = (64'd1 << DATA_W) - 64'd1;
    sh   = int'(b % DATA_W);
    res  = '0;
    ill  = 1'b0;
    case (op)
      4'h0: res = DATA_W'((a + b) & mask);
      4'h1: res = DATA_W'((a - b) & mask);
      4'h2: res = DATA_W'(a & b);
      4'h3: res = DATA_W'(a | b);
      4'h4: res = DATA_W'(a ^ b);
      4'h5: res = DATA_W'((a << sh) & mask);
      4'h6: res = DATA_W'(a >> sh);
      4'h7: res = ($signed(rd_reg(ins[11:8])) < $signed(rd_reg(ins[7:4]))) ? DATA_W'(1) : '0;
      4'h8: if (MUL_EN) res = DATA_W'((a * b) & mask); else ill = 1'b1;
      4'h9: res = DATA_W'(ins[11:4]);
      4'hF: res = '0;
      default: ill = 1'b1;
    endcase
    if (!ill && op != 4'hF && ins[3:0] != 4'd0) m_regs[ins[3:0]] = res;
  endfunction

  task automatic issue(input logic [15:0] ins, input bit noise, output logic [DATA_W-1:0] got);
    logic [DATA_W-1:0] eres;
    logic              eill;
    logic [W-1:0]      e;
    int                lat, exp_lat, guard;
    bit                seen, busy_ok;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    guard = 0;
    while (!bus.instr_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 64'(bus.instr_ready), 64'd1);
    @(posedge clk);
    model(ins, eres, eill);
    exp_q.push_back({eill, ins[3:0], eres});
    exp_lat = (ins[15:12] == 4'h8 && MUL_EN) ? DATA_W + 2 : 2;
    #1;
    // A noisy source presents a junk instruction while the core is busy; it must be ignored.
    if (noise) bus.instr = 16'($urandom);
    else       bus.instr_valid = 1'b0;
    lat = 0; seen = 1'b0; busy_ok = 1'b1; got = '0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.result_valid) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    bus.instr_valid = 1'b0;
    chk("strobe_seen", 64'(seen), 64'd1);
    chk("busy_held", 64'(busy_ok), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    e   = exp_q.pop_front();
    got = bus.result;
    chk("result", 64'(bus.result), 64'(e[DATA_W-1:0]));
    chk("result_rd", 64'(bus.result_rd), 64'(e[DATA_W+3:DATA_W]));
    chk("illegal", 64'(bus.illegal), 64'(e[W-1]));
    @(negedge clk);
    chk("strobe_one_cycle", 64'(bus.result_valid), 64'd0);
    chk("ready_after", 64'(bus.instr_ready), 64'd1);
  endtask

  task automatic reset_mid(input logic [15:0] ins, input int hold);
    bit seen;
    seen            = 1'b0;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (bus.result_valid) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.result_valid) seen = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    exp_q.delete();
    @(negedge clk);
    if (bus.result_valid) seen = 1'b1;
    chk("rst_no_strobe", 64'(seen), 64'd0);
    chk("rst_ready", 64'(bus.instr_ready), 64'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    logic [15:0]       ins;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_in", 64'(bus.instr_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'(bus.instr_ready), 64'd1);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_valid", 64'(bus.result_valid), 64'd0);
    chk("reset_result", 64'(bus.result), 64'd0);
    chk("reset_rd", 64'(bus.result_rd), 64'd0);
    chk("reset_illegal", 64'(bus.illegal), 64'd0);

    issue(ldi(4'd1, 8'd5), 1'b0, got);              chk("t1_ldi_r1", 64'(got), 64'd5);
    issue(ldi(4'd2, 8'd3), 1'b0, got);              chk("t1_ldi_r2", 64'(got), 64'd3);
    issue(rr(4'h0, 4'd1, 4'd2, 4'd3), 1'b0, got);   chk("t1_add", 64'(got), 64'd8);
    issue(rr(4'h1, 4'd2, 4'd1, 4'd4), 1'b0, got);   chk("t2_sub", 64'(got), 64'hFFFF_FFFE);
    issue(rr(4'h7, 4'd2, 4'd1, 4'd7), 1'b0, got);   chk("t2_slt_a", 64'(got), 64'd1);
    issue(rr(4'h7, 4'd4, 4'd1, 4'd7), 1'b0, got);   chk("t2_slt_b", 64'(got), 64'd1);
    issue(ldi(4'd0, 8'h7F), 1'b0, got);             chk("t3_ldi_r0", 64'(got), 64'h7F);
    issue(rr(4'h0, 4'd0, 4'd1, 4'd5), 1'b0, got);   chk("t3_r0_zero", 64'(got), 64'd5);
    issue(rr(4'h8, 4'd1, 4'd2, 4'd6), 1'b0, got);
`ifdef RISC_MUL_EN
    chk("t4_mul", 64'(got), 64'd15);
`else
    chk("t4_mul_off", 64'(got), 64'd0);
`endif
    issue(rr(4'hC, 4'd0, 4'd0, 4'd1), 1'b0, got);   chk("t5_illegal", 64'(got), 64'd0);
    issue(rr(4'h0, 4'd1, 4'd0, 4'd3), 1'b0, got);   chk("t5_r1_kept", 64'(got), 64'd5);
    issue(rr(4'h5, 4'd1, 4'd2, 4'd8), 1'b1, got);   chk("sll_5_3", 64'(got), 64'd40);
    issue(rr(4'h6, 4'd4, 4'd2, 4'd9), 1'b1, got);   chk("srl_fffe_3", 64'(got), 64'h1FFF_FFFF);

`ifdef RISC_MUL_EN
    reset_mid(rr(4'h8, 4'd1, 4'd2, 4'd6), 10);
`else
    reset_mid(rr(4'h8, 4'd1, 4'd2, 4'd6), 1);
`endif
    issue(rr(4'h0, 4'd1, 4'd2, 4'd3), 1'b0, got);   chk("t6_add_cleared", 64'(got), 64'd0);

    for (int n = 0; n < 100; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ins[15:12] = 4'h9;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ins, ($urandom_range(0, 3) == 0), got);
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
